// File: rtl/ssg_param.sv
// rtl/ssg_param.sv - parametrised signal segment generator: builds {pad,len,type,rate,modm} and serialises it DO_W bits per beat
module ssg_param #(
    parameter int                 LEN_W     = 16,
    parameter int                 TYPE_W    = 4,
    parameter int                 RATE_W    = 4,
    parameter int                 MODM_W    = 4,
    parameter logic [RATE_W-1:0]  RATE_CODE = RATE_W'(4'hD),
    parameter logic [MODM_W-1:0]  MODM_CODE = MODM_W'(4'h1),
    parameter int                 PAD_W     = 4,
    parameter logic [PAD_W-1:0]   PAD_VAL   = '1,
    parameter bit                 PARITY_EN = 1'b0,
    parameter int                 DO_W      = 1,
    parameter int                 INIT_W    = 6,
    parameter bit                 MSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic [LEN_W-1:0]  di_len_i,
    input  logic [TYPE_W-1:0] di_type_i,
    input  logic              di_vld_i,
    output logic              di_rdy_o,
    output logic [DO_W-1:0]   do_o,
    output logic              do_vld_o,
    input  logic              do_rdy_i,
    output logic              do_last_o,
    output logic [INIT_W-1:0] do_init_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int TOTAL_W = PAD_W + LEN_W + TYPE_W + RATE_W + MODM_W;
    localparam int DATA_W  = TOTAL_W - PAD_W;
    localparam int BEATS   = TOTAL_W / DO_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [TOTAL_W-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INIT_W-1:0]   init_q, init_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   data;
    logic [PAD_W-1:0]    pad;
    logic [TOTAL_W-1:0]  frame;
    logic [TOTAL_W-1:0]  sreg_shift;
    logic [INIT_W-1:0]   frame_init;
    logic                accept;
    logic                advance;

    always_comb begin
        data = {di_len_i, di_type_i, RATE_CODE, MODM_CODE};
        pad  = PAD_VAL;
        if (PARITY_EN) begin
            pad[0] = ^data;
        end
        frame = {pad, data};
    end

    // The shift register always presents the next beat at the transmit-order head.
    generate
        if (MSB_FIRST) begin : g_msb
            assign do_o       = sreg_q[TOTAL_W-1 -: DO_W];
            assign sreg_shift = sreg_q << DO_W;
            assign frame_init = frame[INIT_W-1:0];
        end else begin : g_lsb
            assign do_o       = sreg_q[DO_W-1:0];
            assign sreg_shift = sreg_q >> DO_W;
            assign frame_init = frame[TOTAL_W-1 -: INIT_W];
        end
    endgenerate

    assign do_vld_o  = (state_q == SEND);
    assign busy_o    = (state_q == SEND);
    assign do_last_o = do_vld_o && (cnt_q == LAST_CNT);
    assign di_rdy_o  = (state_q == IDLE) | (do_vld_o & do_last_o & do_rdy_i);
    assign do_init_o = init_q;
    assign done_o    = done_q;

    assign accept  = di_vld_i & di_rdy_o & ~clr_i;
    assign advance = do_vld_o & do_rdy_i & ~clr_i;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        done_d  = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            done_d = advance & do_last_o;
            if (advance) begin
                if (do_last_o) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    sreg_d = sreg_shift;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            // A new frame taken on the last-beat edge overrides the return to IDLE.
            if (accept) begin
                state_d = SEND;
                sreg_d  = frame;
                cnt_d   = '0;
                init_d  = frame_init;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            init_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ssg_param.sv
// tb/tb_ssg_param.sv - directed self-checking bench for ssg_param
module tb_ssg_param;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [15:0] len;
    logic [3:0]  typ;
    logic        v0, v1, v2, r0, r1, r2;
    logic        d0, d2;
    logic [3:0]  d1;
    logic        dv0, dv1, dv2, dl0, dl1, dl2, dn0, dn1, dn2;
    logic        b0, b1, b2, ir0, ir1, ir2;
    logic [5:0]  ini0, ini1, ini2;

    int checks = 0;
    int errors = 0;

    logic [63:0] got;
    int          nlast, lastk, stallbad, cyc, ndone;

    always #5 clk = ~clk;

    ssg_param u0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .di_len_i(len), .di_type_i(typ),
        .di_vld_i(v0), .di_rdy_o(ir0), .do_o(d0), .do_vld_o(dv0), .do_rdy_i(r0),
        .do_last_o(dl0), .do_init_o(ini0), .done_o(dn0), .busy_o(b0)
    );

    ssg_param #(.DO_W(4), .MSB_FIRST(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .di_len_i(len), .di_type_i(typ),
        .di_vld_i(v1), .di_rdy_o(ir1), .do_o(d1), .do_vld_o(dv1), .do_rdy_i(r1),
        .do_last_o(dl1), .do_init_o(ini1), .done_o(dn1), .busy_o(b1)
    );

    ssg_param #(.PARITY_EN(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .di_len_i(len), .di_type_i(typ),
        .di_vld_i(v2), .di_rdy_o(ir2), .do_o(d2), .do_vld_o(dv2), .do_rdy_i(r2),
        .do_last_o(dl2), .do_init_o(ini2), .done_o(dn2), .busy_o(b2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vld(input int id, input logic val);
        case (id)
            0: v0 = val;
            1: v1 = val;
            default: v2 = val;
        endcase
    endtask

    task automatic set_rdy(input int id, input logic val);
        case (id)
            0: r0 = val;
            1: r1 = val;
            default: r2 = val;
        endcase
    endtask

    task automatic sample(input int id, output logic [3:0] d, output logic vl,
                          output logic la, output logic dn);
        case (id)
            0: begin d = {3'b000, d0}; vl = dv0; la = dl0; dn = dn0; end
            1: begin d = d1;           vl = dv1; la = dl1; dn = dn1; end
            default: begin d = {3'b000, d2}; vl = dv2; la = dl2; dn = dn2; end
        endcase
    endtask

    task automatic start(input int id, input logic [15:0] l, input logic [3:0] t, input bit keep);
        len = l;
        typ = t;
        set_vld(id, 1'b1);
        @(posedge clk); #1;
        if (!keep) set_vld(id, 1'b0);
    endtask

    // Collects nb accepted beats; bp applies the ready pattern 1,0,0,1.
    task automatic run(input int id, input int nb, input int dw, input bit msb, input bit bp,
                       output logic [63:0] g, output int nl, output int lk,
                       output int sb, output int cy, output int nd);
        logic [3:0] pat;
        logic [3:0] d, hd;
        logic       vl, la, dn, hl, hold, rv;
        int         k, ph;
        pat = 4'b1001;
        g = '0; nl = 0; lk = -1; sb = 0; cy = 0; nd = 0;
        k = 0; ph = 0; hold = 1'b0; hd = '0; hl = 1'b0;
        while (k < nb && cy < 400) begin
            rv = bp ? pat[3 - (ph % 4)] : 1'b1;
            ph++;
            set_rdy(id, rv);
            sample(id, d, vl, la, dn);
            if (dn) nd++;
            if (hold) begin
                if (!(vl && d == hd && la == hl)) sb++;
                hold = 1'b0;
            end
            if (vl && rv) begin
                if (msb) g = (g << dw) | 64'(d);
                else     g = g | (64'(d) << (k * dw));
                if (la) begin nl++; lk = k; end
                k++;
            end else if (vl) begin
                hold = 1'b1; hd = d; hl = la;
            end
            @(posedge clk); #1;
            cy++;
        end
        set_rdy(id, 1'b1);
        if (k < nb) chk("beat_timeout", 64'(k), 64'(nb));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; len = '0; typ = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        #2;
        chk("rst_out", {58'(0), d0, dv0, dl0, dn0, b0, ir0}, 64'h1);
        chk("rst_init", 64'(ini0), 64'h0);
        chk("rst_msb_out", {57'(0), d1, dv1, b1, ir1}, 64'h1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Default frame, LSB first, one bit per beat
        start(0, 16'h0123, 4'h5, 1'b0);
        chk("def_init", 64'(ini0), 64'h3C);
        chk("def_busy", {62'(0), dv0, b0}, 64'h3);
        run(0, 32, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("def_frame", got, 64'hF01235D1);
        chk("def_first8", 64'(got[7:0]), 64'hD1);
        chk("def_nlast", 64'(nlast), 64'd1);
        chk("def_lastk", 64'(lastk), 64'd31);
        chk("def_done", {62'(0), dn0, dv0}, 64'h2);
        chk("def_idle", {62'(0), b0, ir0}, 64'h1);
        @(posedge clk); #1;
        chk("def_done_once", 64'(dn0), 64'h0);

        // MSB first, nibble beats
        start(1, 16'h0123, 4'h5, 1'b0);
        chk("msb_init", 64'(ini1), 64'h11);
        chk("msb_beat0", 64'(d1), 64'hF);
        run(1, 8, 4, 1'b1, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("msb_frame", got, 64'hF01235D1);
        chk("msb_lastk", 64'(lastk), 64'd7);
        chk("msb_done", 64'(dn1), 64'h1);

        // Even parity in pad bit 0
        start(2, 16'h0123, 4'h5, 1'b0);
        chk("par_init", 64'(ini2), 64'h38);
        run(2, 32, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("par_even", got, 64'hE01235D1);
        start(2, 16'h0123, 4'h4, 1'b0);
        run(2, 32, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("par_odd", got, 64'hF01234D1);

        // Backpressure
        start(0, 16'h0123, 4'h5, 1'b0);
        run(0, 32, 1, 1'b0, 1'b1, got, nlast, lastk, stallbad, cyc, ndone);
        chk("bp_frame", got, 64'hF01235D1);
        chk("bp_stall_stable", 64'(stallbad), 64'd0);
        chk("bp_cycles", 64'(cyc), 64'd64);
        chk("bp_nlast", 64'(nlast), 64'd1);
        chk("bp_done", 64'(dn0), 64'h1);

        // Back-to-back with di_vld held high
        start(0, 16'h0123, 4'h5, 1'b1);
        len = 16'hABCD; typ = 4'h2;
        run(0, 64, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("b2b_data", got, 64'hFABCD2D1_F01235D1);
        chk("b2b_no_gap", 64'(cyc), 64'd64);
        chk("b2b_nlast", 64'(nlast), 64'd2);
        chk("b2b_done_first", 64'(ndone), 64'd1);
        chk("b2b_done_second", 64'(dn0), 64'h1);
        v0 = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("b2b_clr_idle", {62'(0), dv0, ir0}, 64'h1);

        // Abort at beat 10
        start(0, 16'h0123, 4'h5, 1'b0);
        run(0, 10, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_out", {60'(0), dv0, dl0, dn0, b0}, 64'h0);
        chk("clr_rdy", 64'(ir0), 64'h1);
        chk("clr_init_kept", 64'(ini0), 64'h3C);
        @(posedge clk); #1;
        chk("clr_no_done", 64'(dn0), 64'h0);
        start(0, 16'h0BEE, 4'h4, 1'b0);
        run(0, 32, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("clr_restart", got, 64'hF0BEE4D1);
        chk("clr_restart_done", 64'(dn0), 64'h1);

        // Asynchronous reset mid-frame
        start(0, 16'h0123, 4'h5, 1'b0);
        run(0, 6, 1, 1'b0, 1'b0, got, nlast, lastk, stallbad, cyc, ndone);
        chk("arst_pre", {62'(0), d0, dv0}, 64'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", {58'(0), d0, dv0, dl0, dn0, b0, ir0}, 64'h1);
        chk("arst_init", 64'(ini0), 64'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssg_param.md
Name: ssg_param

Overview:
- Parametrised successor to the fixed 32-bit Signal Segment Generator.
- Builds the frame {padding, length, type, rate, modulation}, with optional even parity, and serialises it DO_W bits per beat.
- Supports LSB-first or MSB-first order, valid/ready handshakes on both sides, back-to-back frames, a synchronous abort and a done pulse.
- Sits between the MAC-side length/type source and the scrambler/encoder, which consumes do_init as its seed.

Parameters:
LEN_W, 16, width of di_len field
TYPE_W, 4, width of di_type field
RATE_W, 4, width of rate field
MODM_W, 4, width of modulation field
RATE_CODE, `PCER, constant rate code placed in rate field
MODM_CODE, `MODM, constant modulation code placed in modulation field
PAD_W, 4, padding width; PAD_W>=1
PAD_VAL, all ones, padding value
PARITY_EN, 0, 1: padding bit 0 replaced by even parity over all non-pad bits
DO_W, 1, bits per output beat; TOTAL_W must be a multiple of DO_W
INIT_W, 6, width of do_init; INIT_W<=TOTAL_W
MSB_FIRST, 0, 0: frame bit 0 sent first; 1: bit TOTAL_W-1 sent first
(derived) TOTAL_W = PAD_W+LEN_W+TYPE_W+RATE_W+MODM_W; BEATS = TOTAL_W/DO_W; CNT_W = max(1,$clog2(BEATS))

Ports:
clk  in  1  working clock
rst  in  1  asynchronous reset, active high
clr  in  1  synchronous abort, active high
di_len  in  LEN_W  PSDU length
di_type  in  TYPE_W  PSDU type
di_vld  in  1  input frame request valid
di_rdy  out  1  input ready
do  out  DO_W  serial beat data
do_vld  out  1  beat valid
do_rdy  in  1  downstream ready
do_last  out  1  marks final beat of frame
do_init  out  INIT_W  last INIT_W bits of current frame in transmit order
done  out  1  one-cycle pulse after final beat accepted
busy  out  1  frame in flight

Behaviour:
- Single clock clk. rst is asynchronous, active high, and is the only reset.
- On rst, every register and output clears: do=0, do_vld=0, do_last=0, do_init=0, done=0, busy=0, FSM=IDLE, beat counter=0. di_rdy is then 1, since state is IDLE.
- Frame layout, MSB..LSB: {PAD, di_len, di_type, RATE_CODE, MODM_CODE}.
- When PARITY_EN=1, pad bit 0 = XOR of frame[TOTAL_W-PAD_W-1:0].
- FSM states IDLE and SEND. di_rdy = (state==IDLE) | (do_vld & do_last & do_rdy); this is a combinational path from do_rdy.
- Accept occurs when di_vld & di_rdy at a clock edge. The frame is latched into a TOTAL_W shift register, counter=0, state=SEND.
- Latency: the first beat is presented with do_vld=1 in the cycle immediately after the accept edge.
- do_init loads on the same accept edge and holds until the next accept.
  - MSB_FIRST=0: do_init = frame[TOTAL_W-1 -: INIT_W].
  - MSB_FIRST=1: do_init = frame[INIT_W-1:0].
- Beat k is the k-th DO_W group in transmit order.
  - MSB_FIRST=0: do = frame[k*DO_W +: DO_W].
  - MSB_FIRST=1: do = frame[TOTAL_W-1-k*DO_W -: DO_W].
- Beat advance happens only when do_vld & do_rdy. While do_rdy=0, do, do_vld and do_last hold stable.
- do_last = 1 exactly on beat BEATS-1.
- On acceptance of the last beat:
  - done pulses 1 for the next cycle.
  - If a new frame is accepted on the same edge, SEND continues with the new beat 0 and there is no bubble.
  - Otherwise state=IDLE and do_vld=0.
- busy = (state==SEND).
- di_len and di_type are sampled only at accept; changes during SEND are ignored.
- clr=1 at an edge:
  - State goes to IDLE; do_vld, do_last and done go to 0; counter goes to 0.
  - do_init is kept.
  - clr has priority over accept and beat advance, and no done pulse is issued.
- di_vld while busy and not on the last accepted beat: held off by di_rdy=0, and no data is lost, provided the upstream holds di_vld.

Test Plan:
- Default params, di_len=16'h0123, di_type=4'h5, RATE_CODE=4'hD, MODM_CODE=4'h1 → frame 32'hF01235D1.
  - do sequence starts 1,0,0,0,1,0,1,1.
  - do_init=6'h3C; 32 beats; do_last on beat 31; done one cycle later.
- Same fields with DO_W=4, MSB_FIRST=1 → beats F,0,1,2,3,5,D,1; do_init=6'h11.
- PARITY_EN=1:
  - di_type=4'h5 → frame 32'hE01235D1 (even data popcount).
  - di_type=4'h4 → frame 32'hF01234D1.
- Backpressure: toggle do_rdy 1,0,0,1 every beat → do and do_last stable while stalled; total accepted beats = 32, bit-exact with the first scenario.
- Back-to-back: hold di_vld=1 with two frames → second frame's beat 0 follows the first frame's last beat with no gap; done pulses once per frame.
- clr asserted at beat 10 → do_vld=0 next cycle, no done, di_rdy=1; a new frame starts cleanly.
- rst asserted mid-frame, asynchronously → all outputs 0 immediately.
